alsu_arbiter: RTL

ALSU_ARBITER -- requirements
Module: alsu_arbiter

---
 rtl/alsu_pkg.sv | 59 +++++
 rtl/alsu_rr_arb2.sv | 21 ++
 rtl/alsu_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU arbiter: command layout, idle command,
// opcode values, FSM states and the invalid-command check.
package alsu_pkg;

    localparam int unsigned CMD_W = 16;
    localparam int unsigned OUT_W = 6;

    // Bit offsets of the command fields
    localparam int unsigned OPCODE_LSB = 13;
    localparam int unsigned A_LSB      = 10;
    localparam int unsigned B_LSB      = 7;
    localparam int unsigned CIN_BIT    = 6;
    localparam int unsigned RED_A_BIT  = 5;
    localparam int unsigned RED_B_BIT  = 4;
    localparam int unsigned BYP_A_BIT  = 3;
    localparam int unsigned BYP_B_BIT  = 2;
    localparam int unsigned DIR_BIT    = 1;
    localparam int unsigned SIN_BIT    = 0;

    localparam logic [2:0] OP_OR     = 3'd0;
    localparam logic [2:0] OP_XOR    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_MUL    = 3'd3;
    localparam logic [2:0] OP_SHIFT  = 3'd4;
    localparam logic [2:0] OP_ROTATE = 3'd5;
    localparam logic [2:0] OP_INV6   = 3'd6;
    localparam logic [2:0] OP_INV7   = 3'd7;

    // Bypass A with A=0: drives the ALSU output register to zero
    localparam logic [CMD_W-1:0] IDLE_CMD = CMD_W'(1) << BYP_A_BIT;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] a;
        logic [2:0] b;
        logic       cin;
        logic       red_op_a;
        logic       red_op_b;
        logic       bypass_a;
        logic       bypass_b;
        logic       direction;
        logic       serial_in;
    } alsu_cmd_t;

    // Reduction is only legal on OR/XOR; opcodes 6 and 7 are undefined
    function automatic logic cmd_invalid(input logic [CMD_W-1:0] cmd);
        alsu_cmd_t c;
        c = alsu_cmd_t'(cmd);
        return ((c.red_op_a | c.red_op_b) & (c.opcode[2] | c.opcode[1]))
             | (c.opcode == OP_INV6) | (c.opcode == OP_INV7);
    endfunction

endpackage

// File: rtl/alsu_rr_arb2.sv
// Two-way round-robin grant.
//   i_req    : pending requests, bit N = requester N
//   i_last   : requester granted last (0 or 1)
//   o_gnt_c  : one-hot grant (combinational), zero when nothing pending
module alsu_rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt_c
);

    // On a tie the requester that was not served last wins
    always_comb begin
        o_gnt_c = 2'b00;
        if (i_req == 2'b11) begin
            o_gnt_c = i_last ? 2'b01 : 2'b10;
        end else begin
            o_gnt_c = i_req;
        end
    end

endmodule

// File: rtl/alsu_arbiter.sv
// Arbitrates two requesters onto one pipelined ALSU and returns the result
// to the requester that issued the command.
//   clk, rst                  : clock, asynchronous active-low reset
//   req0/1_valid, req0/1_cmd  : command requests
//   req0/1_ready              : combinational acceptance (IDLE only)
//   resp0/1_valid             : one-cycle response strobe
//   resp_data, resp_err       : result and invalid-command flag
//   alsu_cmd / alsu_out       : ALSU command out, ALSU result in
//   busy                      : high whenever the FSM is not IDLE
module alsu_arbiter
    import alsu_pkg::*;
#(
    parameter int unsigned ALSU_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [CMD_W-1:0] req0_cmd,
    input  logic             req1_valid,
    input  logic [CMD_W-1:0] req1_cmd,
    output logic             req0_ready,
    output logic             req1_ready,
    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic [OUT_W-1:0] resp_data,
    output logic             resp_err,
    output logic [CMD_W-1:0] alsu_cmd,
    input  logic [OUT_W-1:0] alsu_out,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(ALSU_LATENCY + 2);

    state_e           r_state;
    logic             r_last;
    logic             r_id;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CMD_W-1:0] r_alsu_cmd;
    logic             r_resp0_valid;
    logic             r_resp1_valid;
    logic [OUT_W-1:0] r_resp_data;
    logic             r_resp_err;
    logic             r_busy;

    logic [1:0]       w_gnt;
    logic             w_accept;
    logic [CMD_W-1:0] w_sel_cmd;
    logic             w_sel_inv;

    alsu_rr_arb2 u_arb (
        .i_req   ({req1_valid, req0_valid}),
        .i_last  (r_last),
        .o_gnt_c (w_gnt)
    );

    // Acceptance is only possible in IDLE and never while reset is held
    assign w_accept   = (r_state == ST_IDLE) && rst && (w_gnt != 2'b00);
    assign req0_ready = (r_state == ST_IDLE) && rst && w_gnt[0];
    assign req1_ready = (r_state == ST_IDLE) && rst && w_gnt[1];
    assign w_sel_cmd  = w_gnt[1] ? req1_cmd : req0_cmd;
    assign w_sel_inv  = cmd_invalid(w_sel_cmd);

    // FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_last        <= 1'b1;
            r_id          <= 1'b0;
            r_wait_cnt    <= '0;
            r_alsu_cmd    <= IDLE_CMD;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp_data   <= '0;
            r_resp_err    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_alsu_cmd    <= IDLE_CMD;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id   <= w_gnt[1];
                        r_busy <= 1'b1;
                        if (w_sel_inv) begin
                            // Invalid: answer next cycle, ALSU untouched
                            r_state       <= ST_RESP;
                            r_resp_err    <= 1'b1;
                            r_resp_data   <= '0;
                            r_resp0_valid <= ~w_gnt[1];
                            r_resp1_valid <= w_gnt[1];
                        end else begin
                            r_state    <= ST_WAIT;
                            r_alsu_cmd <= w_sel_cmd;
                            r_wait_cnt <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == CNT_W'(ALSU_LATENCY)) begin
                        r_state       <= ST_RESP;
                        r_resp_data   <= alsu_out;
                        r_resp_err    <= 1'b0;
                        r_resp0_valid <= ~r_id;
                        r_resp1_valid <= r_id;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_last  <= r_id;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign alsu_cmd    = r_alsu_cmd;
    assign resp0_valid = r_resp0_valid;
    assign resp1_valid = r_resp1_valid;
    assign resp_data   = r_resp_data;
    assign resp_err    = r_resp_err;
    assign busy        = r_busy;

endmodule
